// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor-0 register file (Count/Compare timer, Status, Cause, EPC, Config, PRId).
// Latency: MTC0 writes and exception/eret updates are visible one cycle after they are presented;
// MFC0 read is combinational. Backpressure: none -- one write and one exception event every cycle.
//
// Ports:
//   clk, resetn            rising-edge clock, synchronous active-low reset
//   we_i/waddr_i/data_i    MTC0 commit from WB
//   raddr_i -> data_o      MFC0 read of registered values (no write bypass)
//   int_i                  hardware interrupt lines, sampled into Cause[15:10] every cycle
//   excepttype_i, current_inst_addr_i, is_in_delayslot_i   exception/eret event from MEM
//   count_o..prid_o        registered CP0 values fed back to MEM; timer_int_o timer pending
module cp0_reg #(
    parameter logic [31:0] PRID_VAL   = 32'h004c0102,
    parameter logic [31:0] CONFIG_RST = 32'h00008000,
    parameter logic [31:0] STATUS_RST = 32'h10000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;
    localparam logic [4:0] ADDR_CONFIG  = 5'd16;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_config;
    logic        r_timer_int;

    logic        w_exc;
    logic        w_eret;
    logic [4:0]  w_exccode;
    logic [31:0] w_status_nxt;
    logic [31:0] w_cause_nxt;
    logic [31:0] w_epc_nxt;

    // Decode the exception event; unknown nonzero codes are dropped.
    always_comb begin
        w_exc     = 1'b1;
        w_eret    = 1'b0;
        w_exccode = 5'd0;
        case (excepttype_i)
            32'h0000_0001: w_exccode = 5'd0;
            32'h0000_0008: w_exccode = 5'd8;
            32'h0000_000a: w_exccode = 5'd10;
            32'h0000_000c: w_exccode = 5'd12;
            32'h0000_000d: w_exccode = 5'd13;
            32'h0000_000e: begin
                w_exc  = 1'b0;
                w_eret = 1'b1;
            end
            default:       w_exc = 1'b0;
        endcase
    end

    // MTC0 is applied first, then exception/eret field updates override it.
    // The EXL test for a nested exception uses the post-MTC0 Status value,
    // since the MTC0 belongs to an older instruction.
    always_comb begin
        w_status_nxt = r_status;
        w_cause_nxt  = r_cause;
        w_epc_nxt    = r_epc;

        if (we_i && waddr_i == ADDR_STATUS) w_status_nxt = data_i;
        if (we_i && waddr_i == ADDR_EPC)    w_epc_nxt    = data_i;
        if (we_i && waddr_i == ADDR_CAUSE) begin
            w_cause_nxt[9:8] = data_i[9:8];
            w_cause_nxt[22]  = data_i[22];
            w_cause_nxt[23]  = data_i[23];
        end
        // Hardware interrupt pending bits track the pins, never the write data.
        w_cause_nxt[15:10] = int_i;

        if (w_exc) begin
            if (!w_status_nxt[1]) begin
                w_epc_nxt       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                    : current_inst_addr_i;
                w_cause_nxt[31] = is_in_delayslot_i;
            end
            w_status_nxt[1]  = 1'b1;
            w_cause_nxt[6:2] = w_exccode;
        end else if (w_eret) begin
            w_status_nxt[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= STATUS_RST;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_config    <= CONFIG_RST;
            r_timer_int <= 1'b0;
        end else begin
            if (we_i && waddr_i == ADDR_COUNT) r_count <= data_i;
            else                               r_count <= r_count + 32'd1;

            // Compare write both reloads and acknowledges; it beats a same-cycle match.
            if (we_i && waddr_i == ADDR_COMPARE) begin
                r_compare   <= data_i;
                r_timer_int <= 1'b0;
            end else if (r_compare != 32'd0 && r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end

            if (we_i && waddr_i == ADDR_CONFIG) r_config <= data_i;

            r_status <= w_status_nxt;
            r_cause  <= w_cause_nxt;
            r_epc    <= w_epc_nxt;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            ADDR_COUNT:   data_o = r_count;
            ADDR_COMPARE: data_o = r_compare;
            ADDR_STATUS:  data_o = r_status;
            ADDR_CAUSE:   data_o = r_cause;
            ADDR_EPC:     data_o = r_epc;
            ADDR_PRID:    data_o = PRID_VAL;
            ADDR_CONFIG:  data_o = r_config;
            default:      data_o = 32'd0;
        endcase
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign config_o    = r_config;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed stimulus for cp0_reg with a cycle-tagged scoreboard.
// Stimulus pushes (cycle, signal, expected) entries; a negedge monitor pops and compares.
// No handshake on the DUT, so the cycle tag stands in for a valid strobe.
module tb_cp0_reg;

    logic        clk;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk                 (clk),
        .resetn              (resetn),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    localparam int S_COUNT   = 0;
    localparam int S_COMPARE = 1;
    localparam int S_STATUS  = 2;
    localparam int S_CAUSE   = 3;
    localparam int S_EPC     = 4;
    localparam int S_CONFIG  = 5;
    localparam int S_PRID    = 6;
    localparam int S_TIMER   = 7;
    localparam int S_DATA    = 8;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            S_COUNT:   return "count_o";
            S_COMPARE: return "compare_o";
            S_STATUS:  return "status_o";
            S_CAUSE:   return "cause_o";
            S_EPC:     return "epc_o";
            S_CONFIG:  return "config_o";
            S_PRID:    return "prid_o";
            S_TIMER:   return "timer_int_o";
            default:   return "data_o";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_COUNT:   return count_o;
            S_COMPARE: return compare_o;
            S_STATUS:  return status_o;
            S_CAUSE:   return cause_o;
            S_EPC:     return epc_o;
            S_CONFIG:  return config_o;
            S_PRID:    return prid_o;
            S_TIMER:   return {31'd0, timer_int_o};
            default:   return data_o;
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        q.push_back(e);
    endtask

    // Monitor: compares every entry whose cycle tag has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = sample(e.sel);
            n_cmp++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s @cyc%0d: entry missed, checked at cyc %0d", sel_name(e.sel), e.cyc, cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s @cyc%0d: got %08h, want %08h", sel_name(e.sel), cyc, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        data_i  = d;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
        excepttype_i        = t;
        current_inst_addr_i = pc;
        is_in_delayslot_i   = ds;
    endtask

    task automatic idle();
        we_i         = 1'b0;
        excepttype_i = 32'd0;
        is_in_delayslot_i = 1'b0;
    endtask

    int k;

    initial begin
        resetn = 1'b0;
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0; int_i = 6'd0;
        excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;

        // Reset held for two edges.
        step(); step();
        expect_at(cyc, S_STATUS,  32'h10000000);
        expect_at(cyc, S_CONFIG,  32'h00008000);
        expect_at(cyc, S_COUNT,   32'd0);
        expect_at(cyc, S_COMPARE, 32'd0);
        expect_at(cyc, S_CAUSE,   32'd0);
        expect_at(cyc, S_EPC,     32'd0);
        expect_at(cyc, S_TIMER,   32'd0);
        expect_at(cyc, S_PRID,    32'h004c0102);
        resetn = 1'b1;
        expect_at(cyc + 1, S_COUNT, 32'd1);
        step();

        // Cause write mask with live interrupt pins.
        mtc0(5'd13, 32'hFFFFFFFF);
        int_i = 6'b000101;
        expect_at(cyc + 1, S_CAUSE, 32'h00C01700);
        step();
        mtc0(5'd13, 32'd0);
        int_i = 6'd0;
        expect_at(cyc + 1, S_CAUSE, 32'd0);
        step();

        // Timer: Compare=0x10, Count=0x0C, match four cycles later.
        mtc0(5'd11, 32'h10);
        expect_at(cyc + 1, S_COMPARE, 32'h10);
        expect_at(cyc + 1, S_TIMER,   32'd0);
        step();
        mtc0(5'd9, 32'h0C);
        expect_at(cyc + 1, S_COUNT, 32'h0C);
        step();
        idle();
        k = cyc;
        expect_at(k + 3, S_TIMER, 32'd0);
        expect_at(k + 4, S_COUNT, 32'h10);
        expect_at(k + 4, S_TIMER, 32'd0);
        expect_at(k + 5, S_TIMER, 32'd1);
        expect_at(k + 6, S_TIMER, 32'd1);
        repeat (6) step();
        mtc0(5'd11, 32'h100);
        expect_at(cyc + 1, S_TIMER,   32'd0);
        expect_at(cyc + 1, S_COMPARE, 32'h100);
        step();
        idle();

        // MFC0 reads.
        raddr_i = 5'd11; expect_at(cyc, S_DATA, 32'h100);       step();
        raddr_i = 5'd15; expect_at(cyc, S_DATA, 32'h004c0102);  step();
        raddr_i = 5'd3;  expect_at(cyc, S_DATA, 32'd0);         step();
        raddr_i = 5'd12; expect_at(cyc, S_DATA, 32'h10000000);  step();

        // Syscall in a delay slot with EXL=0.
        exc(32'h8, 32'hBFC00104, 1'b1);
        expect_at(cyc + 1, S_EPC,    32'hBFC00100);
        expect_at(cyc + 1, S_CAUSE,  32'h80000020);
        expect_at(cyc + 1, S_STATUS, 32'h10000002);
        step();
        // Nested overflow: EPC and BD hold, ExcCode updates.
        exc(32'hC, 32'hBFC00200, 1'b0);
        expect_at(cyc + 1, S_EPC,    32'hBFC00100);
        expect_at(cyc + 1, S_CAUSE,  32'h80000030);
        expect_at(cyc + 1, S_STATUS, 32'h10000002);
        step();
        // ERET clears EXL only.
        exc(32'hE, 32'hBFC00300, 1'b0);
        expect_at(cyc + 1, S_STATUS, 32'h10000000);
        expect_at(cyc + 1, S_EPC,    32'hBFC00100);
        expect_at(cyc + 1, S_CAUSE,  32'h80000030);
        step();
        // Unknown code is ignored.
        exc(32'h5, 32'h00000444, 1'b1);
        expect_at(cyc + 1, S_STATUS, 32'h10000000);
        expect_at(cyc + 1, S_EPC,    32'hBFC00100);
        step();
        idle();

        // MTC0 EPC collides with a trap: exception value wins.
        mtc0(5'd14, 32'h12345678);
        exc(32'hD, 32'h80000040, 1'b0);
        expect_at(cyc + 1, S_EPC,    32'h80000040);
        expect_at(cyc + 1, S_CAUSE,  32'h00000034);
        expect_at(cyc + 1, S_STATUS, 32'h10000002);
        step();
        idle();
        exc(32'hE, 32'h0, 1'b0);
        step();
        idle();
        mtc0(5'd14, 32'h12345678);
        expect_at(cyc + 1, S_EPC,    32'h12345678);
        expect_at(cyc + 1, S_STATUS, 32'h10000000);
        step();
        mtc0(5'd16, 32'hA5A50000);
        expect_at(cyc + 1, S_CONFIG, 32'hA5A50000);
        step();
        mtc0(5'd20, 32'hDEADBEEF);
        expect_at(cyc + 1, S_CONFIG, 32'hA5A50000);
        expect_at(cyc + 1, S_EPC,    32'h12345678);
        step();

        // Count wrap.
        mtc0(5'd9, 32'hFFFFFFFF);
        expect_at(cyc + 1, S_COUNT, 32'hFFFFFFFF);
        expect_at(cyc + 2, S_COUNT, 32'd0);
        step();
        idle();
        step();

        // Reset mid-exception and mid-write.
        resetn = 1'b0;
        mtc0(5'd12, 32'hFFFFFFFF);
        exc(32'h8, 32'h80001000, 1'b1);
        expect_at(cyc + 1, S_STATUS,  32'h10000000);
        expect_at(cyc + 1, S_EPC,     32'd0);
        expect_at(cyc + 1, S_CAUSE,   32'd0);
        expect_at(cyc + 1, S_COUNT,   32'd0);
        expect_at(cyc + 1, S_COMPARE, 32'd0);
        expect_at(cyc + 1, S_CONFIG,  32'h00008000);
        step();
        idle();
        resetn = 1'b1;

        // Drain the scoreboard within a bounded window.
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s @cyc%0d: never checked, want %08h", sel_name(e.sel), e.cyc, e.val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
